divider_block_16: RTL and testbench
===================================

Name: divider_block_16

Overview:
- Downstream of the exp/adder stages in the 16-bit softmax datapath.
- Buffers the number_of_data exponent values as the exp unit emits them, then waits for the accumulated sum from the adder stage.
- Produces one normalised softmax output per element, exp/sum, using a bit-serial restoring divider.
- Output stream feeds the softmax result interface.

Parameters:
- data_size, 16, width of exp, sum and output words (arithmetic below is fixed for 16).
- number_of_data, 10, elements per softmax vector; buffer depth.

Ports:
- clock_i  input  1  single clock, all logic on rising edge
- reset_i  input  1  synchronous, active-high reset
- exp_data_i  input  data_size  exponent value, unsigned Q0.16
- exp_data_valid_i  input  1  exp_data_i valid this cycle (same strobe the adder stage sees)
- sum_data_i  input  data_size  accumulated sum from adder stage, unsigned Q4.12
- sum_data_valid_i  input  1  sum valid; level, held high by adder once asserted
- divider_data_o  output  data_size  softmax result, unsigned Q0.16
- divider_data_valid_o  output  1  one-cycle pulse per result
- divider_done_o  output  1  all number_of_data results emitted; sticky

Behaviour:
- Reset (reset_i=1 at a clock edge):
  - state=LOAD, write count=0, read index=0.
  - divider_data_o=0, divider_data_valid_o=0, divider_done_o=0.
  - Buffer contents don't-care.
  - Reset mid-operation aborts the current vector with no partial output.
- LOAD:
  - Each cycle exp_data_valid_i=1 and count<number_of_data: buffer[count]<=exp_data_i, count+1.
  - Valids once count==number_of_data are ignored (no wrap, no overwrite).
  - When sum_data_valid_i=1 and count==number_of_data, latch sum_data_i into the divisor register and go to CHECK.
  - sum valid with count<number_of_data: stay in LOAD, keep waiting.
  - Exp write and sum sample in the same cycle: the write counts first, so the 10th write plus sum valid in one cycle starts the division.
- CHECK (1 cycle):
  - e=buffer[index], s=latched sum.
  - If e >= 16*s (includes s==0): result saturates to 0xFFFF; skip DIV, go to OUT.
  - Otherwise load the 28-bit dividend e<<12, clear the partial remainder, go to DIV.
- DIV (exactly 16 cycles):
  - Restoring division, one quotient bit per cycle, MSB first.
  - The remainder must hold 17 bits.
  - Result = floor(e*4096/s), guaranteed <=0xFFFF by the CHECK.
  - Saturated elements still take 16 idle cycles, so spacing is uniform.
- OUT (1 cycle):
  - divider_data_o<=result, divider_data_valid_o=1.
  - If index==number_of_data-1, go to DONE; else index+1, go to CHECK.
- DONE:
  - divider_done_o=1 from the cycle after the last valid pulse, held until reset.
  - divider_data_o holds the last result.
  - All inputs ignored; a new vector requires reset.
- Timing:
  - The start edge (sum sampled) is cycle 0.
  - First divider_data_valid_o is in cycle 18; subsequent pulses every 18 cycles.
  - Last pulse in cycle 18*number_of_data (180 at default); done in cycle 181.
- exp_data_valid_i outside LOAD is ignored.
- divider_data_o changes only in OUT (or reset).

Test Plan:
- Basic: 10 writes e=0x1000, sum=0x1000 (1.0) -> ten pulses of 0x1000 at cycles 18,36,…,180; done high at cycle 181 and stays high.
- Uniform vector: 10 writes e=0x1999 with real adder output sum=0x0FFF -> every result 0x199A.
- Saturation and zero sum:
  - e=0x2000, sum=0x0100 -> 0xFFFF with 18-cycle spacing preserved.
  - sum=0x0000 -> all ten results 0xFFFF.
- Ordering/overflow: e=0x0100*k for k=1..10, then 3 extra valids of 0xFFFF, sum=0x1000 -> outputs 0x0100..0x0A00 in order; extra writes have no effect.
- Early sum:
  - sum_data_valid_i high after 6 writes -> no output while waiting.
  - Division starts on the cycle after the 10th write; first pulse 18 cycles after that start edge.
- Reset mid-DIV during element 3 -> next cycle all outputs 0 and state LOAD; a fresh vector then completes correctly.

Source files
------------

// File: rtl/divider_block_16.sv
// divider_block_16
//   Final stage of the 16-bit softmax datapath. It buffers number_of_data
//   exponent values (Q0.16) and then waits for the accumulated sum (Q4.12).
//   For each buffered element it emits exp/sum as a Q0.16 result, computed
//   with a bit-serial restoring divider.
//
// Ports
//   clock_i              rising-edge clock
//   reset_i              synchronous, active-high reset
//   exp_data_i           exponent value, unsigned Q0.16
//   exp_data_valid_i     exp_data_i strobe
//   sum_data_i           accumulated sum, unsigned Q4.12
//   sum_data_valid_i     sum valid (level, held by the adder stage)
//   divider_data_o       softmax result, unsigned Q0.16
//   divider_data_valid_o one-cycle pulse per result
//   divider_done_o       sticky, all results emitted
module divider_block_16 #(
   parameter int data_size      = 16,
   parameter int number_of_data = 10
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic [data_size-1:0] exp_data_i,
   input  logic                 exp_data_valid_i,
   input  logic [data_size-1:0] sum_data_i,
   input  logic                 sum_data_valid_i,
   output logic [data_size-1:0] divider_data_o,
   output logic                 divider_data_valid_o,
   output logic                 divider_done_o
);

   localparam int CW = $clog2(number_of_data + 1);
   localparam logic [CW-1:0] n_full = CW'(number_of_data);
   localparam logic [CW-1:0] n_last = CW'(number_of_data - 1);

   typedef enum logic [2:0] {LOAD, CHECK, DIV, OUT, DONE} state_t;

   state_t                 state;
   logic [data_size-1:0]   buffer [number_of_data];
   logic [CW-1:0]          count;
   logic [CW-1:0]          index;
   logic [data_size-1:0]   divisor;
   logic [data_size:0]     rem;     // 17-bit partial remainder
   logic [data_size-1:0]   quot;    // remaining dividend bits shift out, quotient bits shift in
   logic [3:0]             step;
   logic                   sat;

   logic [data_size-1:0]   elem;
   logic [data_size:0]     trial;
   logic                   fits;
   logic                   too_big;
   logic                   start;

   always_comb begin
      elem    = buffer[index];
      trial   = {rem[data_size-1:0], quot[data_size-1]};
      fits    = trial >= {1'b0, divisor};
      // e*4096/s overflows 16 bits exactly when e >= 16*s (s==0 included)
      too_big = {4'b0, elem} >= {divisor, 4'b0};
      // the 10th write and the sum may land in the same cycle
      start   = sum_data_valid_i &&
                ((count == n_full) || ((count == n_last) && exp_data_valid_i));
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state                <= LOAD;
         count                <= '0;
         index                <= '0;
         divisor              <= '0;
         rem                  <= '0;
         quot                 <= '0;
         step                 <= '0;
         sat                  <= 1'b0;
         divider_data_o       <= '0;
         divider_data_valid_o <= 1'b0;
         divider_done_o       <= 1'b0;
      end else begin
         divider_data_valid_o <= 1'b0;
         case (state)
            LOAD: begin
               if (exp_data_valid_i && (count < n_full)) begin
                  buffer[count] <= exp_data_i;
                  count         <= count + 1'b1;
               end
               if (start) begin
                  divisor <= sum_data_i;
                  state   <= CHECK;
               end
            end
            CHECK: begin
               // Dividend is e<<12. Since e < 16*s, the top 12 quotient bits are
               // zero and the remainder after those 12 shifts is simply e[15:4],
               // so only the low 16 dividend bits remain to be processed.
               sat   <= too_big;
               rem   <= {5'b0, elem[data_size-1:4]};
               quot  <= {elem[3:0], 12'b0};
               step  <= '0;
               state <= DIV;
            end
            DIV: begin
               // saturated elements still run the 16 steps to keep spacing uniform
               rem   <= fits ? (trial - {1'b0, divisor}) : trial;
               quot  <= {quot[data_size-2:0], fits};
               step  <= step + 1'b1;
               if (step == 4'd15) state <= OUT;
            end
            OUT: begin
               divider_data_o       <= sat ? '1 : quot;
               divider_data_valid_o <= 1'b1;
               if (index == n_last) begin
                  state <= DONE;
               end else begin
                  index <= index + 1'b1;
                  state <= CHECK;
               end
            end
            DONE: begin
               divider_done_o <= 1'b1;
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_block_16.sv
// tb_divider_block_16
//   Directed bench for divider_block_16: basic, uniform, saturation, zero-sum,
//   ordering/overflow, early-sum and mid-division reset vectors.
module tb_divider_block_16;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic [15:0] exp_data_i;
   logic        exp_data_valid_i;
   logic [15:0] sum_data_i;
   logic        sum_data_valid_i;
   logic [15:0] divider_data_o;
   logic        divider_data_valid_o;
   logic        divider_done_o;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] exp_res [10];

   divider_block_16 dut (
      .clock_i              (clock_i),
      .reset_i              (reset_i),
      .exp_data_i           (exp_data_i),
      .exp_data_valid_i     (exp_data_valid_i),
      .sum_data_i           (sum_data_i),
      .sum_data_valid_i     (sum_data_valid_i),
      .divider_data_o       (divider_data_o),
      .divider_data_valid_o (divider_data_valid_o),
      .divider_done_o       (divider_done_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      reset_i          = 1'b1;
      exp_data_valid_i = 1'b0;
      sum_data_valid_i = 1'b0;
      exp_data_i       = '0;
      sum_data_i       = '0;
      tick();
      tick();
      reset_i = 1'b0;
   endtask

   task automatic write(input logic [15:0] v);
      exp_data_i       = v;
      exp_data_valid_i = 1'b1;
      tick();
      exp_data_valid_i = 1'b0;
   endtask

   // Current time is just after the start edge (cycle 0).
   task automatic run_check(input string tag);
      int n = 0;
      for (int cyc = 1; cyc <= 185; cyc++) begin
         tick();
         if (divider_data_valid_o) begin
            if (n < 10) begin
               check({tag, "_data"}, divider_data_o, exp_res[n]);
               check({tag, "_cycle"}, cyc, 18 * (n + 1));
            end
            n++;
         end
         if (cyc == 180) check({tag, "_done_early"}, divider_done_o, 1'b0);
         if (cyc == 181) check({tag, "_done"}, divider_done_o, 1'b1);
      end
      check({tag, "_pulses"}, n, 10);
      check({tag, "_done_held"}, divider_done_o, 1'b1);
      check({tag, "_data_held"}, divider_data_o, exp_res[9]);
   endtask

   initial begin
      do_reset();
      check("reset_data", divider_data_o, 16'h0000);
      check("reset_valid", divider_data_valid_o, 1'b0);
      check("reset_done", divider_done_o, 1'b0);

      // basic: 1.0 / 1.0
      for (int i = 0; i < 10; i++) write(16'h1000);
      sum_data_i = 16'h1000; sum_data_valid_i = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) exp_res[i] = 16'h1000;
      run_check("basic");

      // uniform: 6553*4096/4095 = 6554.6 -> 0x199A
      do_reset();
      for (int i = 0; i < 10; i++) write(16'h1999);
      sum_data_i = 16'h0FFF; sum_data_valid_i = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) exp_res[i] = 16'h199A;
      run_check("uniform");

      // saturation: 0x2000 >= 16*0x0100
      do_reset();
      for (int i = 0; i < 10; i++) write(16'h2000);
      sum_data_i = 16'h0100; sum_data_valid_i = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) exp_res[i] = 16'hFFFF;
      run_check("sat");

      // zero sum
      do_reset();
      for (int i = 0; i < 10; i++) write(16'(i * 16'h0123));
      sum_data_i = 16'h0000; sum_data_valid_i = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) exp_res[i] = 16'hFFFF;
      run_check("zero_sum");

      // ordering and overflow writes
      do_reset();
      for (int k = 1; k <= 10; k++) write(16'(k * 16'h0100));
      for (int i = 0; i < 3; i++) write(16'hFFFF);
      sum_data_i = 16'h1000; sum_data_valid_i = 1'b1;
      tick();
      for (int k = 1; k <= 10; k++) exp_res[k-1] = 16'(k * 16'h0100);
      run_check("order");

      // early sum: sum held from write 6; the 10th write edge is the start edge
      do_reset();
      for (int i = 0; i < 6; i++) write(16'h0800);
      sum_data_i = 16'h1000; sum_data_valid_i = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (divider_data_valid_o) check("early_idle", divider_data_valid_o, 1'b0);
      end
      check("early_idle_end", divider_data_valid_o, 1'b0);
      for (int i = 0; i < 4; i++) write(16'h0800);
      for (int i = 0; i < 10; i++) exp_res[i] = 16'h0800;
      run_check("early");

      // reset while element 3 is dividing, then a fresh vector
      do_reset();
      for (int i = 0; i < 10; i++) write(16'h1000);
      sum_data_i = 16'h1000; sum_data_valid_i = 1'b1;
      tick();
      for (int cyc = 1; cyc <= 41; cyc++) tick();
      check("mid_pre_data", divider_data_o, 16'h1000);
      reset_i = 1'b1;
      sum_data_valid_i = 1'b0;
      tick();
      check("mid_rst_data", divider_data_o, 16'h0000);
      check("mid_rst_valid", divider_data_valid_o, 1'b0);
      check("mid_rst_done", divider_done_o, 1'b0);
      reset_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (divider_data_valid_o) check("mid_quiet", divider_data_valid_o, 1'b0);
      end
      for (int i = 0; i < 10; i++) write(16'h1999);
      sum_data_i = 16'h0FFF; sum_data_valid_i = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) exp_res[i] = 16'h199A;
      run_check("after_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
